hcf_unit: RTL
=============

# hcf_unit

Multi-cycle highest-common-factor (GCD) execution unit for the HCF custom instruction. Consumes the two source operands read from the 32-entry register file read ports, computes HCF by iterative subtraction, and drives the register file write port (regwrite, write_reg, write_data) for one cycle to retire the result. The pipeline control stalls issue while busy is high.

## Interface

- WIDTH, 32: operand and result width; must match register file data width.
- CNT_WIDTH, 16: width of the saturating iteration counter.

- clock  in  1  rising-edge clock shared with the register file.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  in  1  issue request; sampled only in IDLE.
- operand_a  in  WIDTH  first operand (register file read_data1).
- operand_b  in  WIDTH  second operand (register file read_data2).
- dest_reg  in  5  destination register number.
- abort  in  1  cancel an in-flight computation; honoured only in CALC.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  last computed HCF; holds until the next completion.
- iter_count  out  CNT_WIDTH  subtractions performed by the last/current op; saturates at all-ones.
- regwrite  out  1  register file write enable.
- write_reg  out  5  register file write address.
- write_data  out  WIDTH  register file write data.

## Operation

- States: IDLE, CALC, DONE. Reset state IDLE.
- IDLE: on start=1, capture a<=operand_a, b<=operand_b, dest<=dest_reg, iter_count<=0, go to CALC. Otherwise stay.
- CALC, evaluated each cycle in priority order:
  - abort=1: go to IDLE; no write, no done, result unchanged.
  - a==0 or b==0 or a==b: res<=(a==0 ? b : a); go to DONE.
  - a>b: a<=a-b; iter_count+1 (saturating).
  - else: b<=b-a; iter_count+1 (saturating).
- DONE (exactly one cycle): done=1; result=res; write_data=res; write_reg=dest; regwrite=1 unless dest==0, in which case regwrite=0 (x0 is never written). Then go to IDLE.
- HCF(0,0)=0. HCF(0,x)=x. Subtraction never underflows: the smaller operand is always the subtrahend.
- start while busy: ignored, with no queuing. abort in IDLE or DONE: ignored.
- regwrite, write_reg and write_data are 0 in every cycle except DONE.
- Operands are unsigned. 32'h80000000 is treated as 2147483648.

## Timing

- Reset values: busy=0, done=0, regwrite=0, write_reg=0, write_data=0, result=0, iter_count=0. State goes to IDLE asynchronously on reset=0.
- Let E0 be the edge that samples start, and N the number of subtractions.
- CALC spans edges E1..E(N+1).
- done, regwrite and write data become valid after edge E(N+1) and clear after E(N+2). Total latency is N+1 edges from E0.
- busy rises after E0 and falls after E(N+2).
- A new start is accepted at the first edge after busy falls. Back-to-back issue spacing is N+3 edges.
- Reset asserted mid-CALC or in DONE: no write occurs, even if DONE was already entered; everything clears immediately.
- The register file write occurs on the clock edge that ends the DONE cycle.
- Worst case for WIDTH=32, HCF(FFFFFFFF,1): N=2^32-2. Control must use abort or a timeout if bounded latency is required. iter_count saturates at 16'hFFFF.

## Test plan

- Reset: hold reset=0 for 2 cycles, then release -> all outputs 0, busy=0; start with (48,18) accepted on the next edge.
- Basic: start (48,18) dest=25 -> N=4, done and regwrite 5 edges after start; write_reg=25, write_data=6, iter_count=4. Also (12,8)->4 (N=2, dest 26), (15,10)->5 (N=2, dest 27), (9,9)->9 (N=0, done 1 edge after start, dest 28).
- Zero and max operands: (0,7)->7 (N=0); (0,0)->0; (FFFFFFFF,FFFFFFFF)->FFFFFFFF (N=0); (80000000,40000000)->40000000 (N=1).
- x0 protection: start (48,18) dest=0 -> done=1, result=6, regwrite=0 during DONE.
- Abort and ignored start: start (48,18), assert abort at the 2nd CALC cycle -> IDLE next edge, no done, no regwrite, result keeps its prior value. Start pulsed while busy -> ignored, and the original op completes unchanged.
- Async reset mid-op: start (1000,3), drop reset to 0 mid-CALC -> busy=0 immediately, no regwrite ever asserted; a subsequent (12,8) returns 4.

Source files
------------

// File: rtl/hcf_unit.sv
// hcf_unit: multi-cycle highest-common-factor execution unit.
//
// Computes HCF(operand_a, operand_b) by repeated subtraction of the smaller
// operand from the larger, then retires the result through the register
// file write port for exactly one cycle.
//
// Ports:
//   clock       rising-edge clock (shared with the register file)
//   reset       asynchronous active-low reset
//   start       issue request, sampled only while idle
//   operand_a   first operand  (register file read_data1)
//   operand_b   second operand (register file read_data2)
//   dest_reg    destination register number
//   abort       cancel an in-flight computation (honoured only in CALC)
//   busy        high while computing or retiring
//   done        one-cycle completion pulse
//   result      last completed HCF, held until the next completion
//   iter_count  subtractions of the last/current operation, saturating
//   regwrite    register file write enable (never asserted for x0)
//   write_reg   register file write address
//   write_data  register file write data
module hcf_unit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  input  logic [4:0]           dest_reg,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [CNT_WIDTH-1:0] iter_count,
  output logic                 regwrite,
  output logic [4:0]           write_reg,
  output logic [WIDTH-1:0]     write_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [WIDTH-1:0]       res_q, res_d;
  logic [4:0]             dest_q, dest_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   finish;

  // Counter sticks at all-ones so a very long run still reads as "maximum".
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Either operand reaching zero, or both equal, means the other one is the HCF.
  assign finish = (a_q == '0) || (b_q == '0) || (a_q == b_q);

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      dest_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC: begin
        if (abort)       state_d = IDLE;
        else if (finish) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    dest_d = dest_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = operand_a;
          b_d    = operand_b;
          dest_d = dest_reg;
          cnt_d  = '0;
        end
      end
      CALC: begin
        // Abort leaves everything, including the held result, untouched.
        if (!abort) begin
          if (finish) begin
            res_d = (a_q == '0) ? b_q : a_q;
          end else if (a_q > b_q) begin
            a_d   = a_q - b_q;
            cnt_d = sat_inc(cnt_q);
          end else begin
            b_d   = b_q - a_q;
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs: the write port is quiet outside DONE, and x0 is never written.
  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    regwrite   = (state_q == DONE) && (dest_q != 5'd0);
    write_reg  = (state_q == DONE) ? dest_q : 5'd0;
    write_data = (state_q == DONE) ? res_q : '0;
    result     = res_q;
    iter_count = cnt_q;
  end

endmodule
